bist_signature_analyzer: RTL and testbench

//  Downstream of the BIST controller. Compacts the circuit-under-test response word

---
 rtl/bist_signature_analyzer_if.sv | 23 ++
 rtl/bist_signature_analyzer.sv | 89 ++++++++
 tb/tb_bist_signature_analyzer.sv | 118 +++++++++++
 3 files changed

// File: rtl/bist_signature_analyzer_if.sv
// bist_signature_analyzer_if: controller-side stimulus and verdict signals of the signature analyzer
interface bist_signature_analyzer_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             running;
  logic             bist_end;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] signature;
  logic [CNT_W-1:0] cycle_count;
  logic             done;
  logic             pass;
  logic             fail;
  logic             aborted;
  modport master (
    output running, bist_end, data_in,
    input  signature, cycle_count, done, pass, fail, aborted
  );
  modport slave (
    input  running, bist_end, data_in,
    output signature, cycle_count, done, pass, fail, aborted
  );
endinterface

// File: rtl/bist_signature_analyzer.sv
// bist_signature_analyzer: MISR response compaction with golden signature/cycle-count verdict
module bist_signature_analyzer #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] POLY       = 16'h1021,
  parameter logic [WIDTH-1:0] SEED       = '0,
  parameter logic [WIDTH-1:0] GOLDEN     = 16'h0000,
  parameter int               CNT_W      = 8,
  parameter int               EXP_CYCLES = 72
) (
  input logic                     clk,
  input logic                     reset,
  bist_signature_analyzer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COMPACT, COMPARE, RESULT} state_t;
  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_sig, w_sig, w_step, w_seed_step;
  logic [CNT_W-1:0] r_cnt, w_cnt, w_cnt_inc;
  logic             r_done, r_pass, r_fail, r_aborted;
  logic             w_done, w_pass, w_fail, w_aborted, w_match;
  assign w_step      = {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : '0) ^ bus.data_in;
  assign w_seed_step = {SEED[WIDTH-2:0], 1'b0} ^ (SEED[WIDTH-1] ? POLY : '0) ^ bus.data_in;
  assign w_cnt_inc   = &r_cnt ? r_cnt : r_cnt + 1'b1;
  assign w_match     = (r_sig == GOLDEN) && (r_cnt == CNT_W'(EXP_CYCLES));
  // next-state, signature/count update and verdict decode
  always_comb begin
    w_state   = r_state;
    w_sig     = r_sig;
    w_cnt     = r_cnt;
    w_done    = r_done;
    w_pass    = r_pass;
    w_fail    = r_fail;
    w_aborted = 1'b0;
    case (r_state)
      IDLE, RESULT: if (bus.running) begin
        w_state = COMPACT;
        w_sig   = w_seed_step;
        w_cnt   = CNT_W'(1);
        w_done  = 1'b0;
        w_pass  = 1'b0;
        w_fail  = 1'b0;
      end
      COMPACT: if (bus.running) begin
        w_sig   = w_step;
        w_cnt   = w_cnt_inc;
        w_state = bus.bist_end ? COMPARE : COMPACT;
      end else if (bus.bist_end) begin
        w_state = COMPARE;
      end else begin
        w_state   = IDLE;
        w_sig     = SEED;
        w_cnt     = '0;
        w_aborted = 1'b1;
      end
      COMPARE: begin
        w_state = RESULT;
        w_done  = 1'b1;
        w_pass  = w_match;
        w_fail  = ~w_match;
      end
      default: w_state = IDLE;
    endcase
  end
  // state and output registers, reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_sig     <= SEED;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_sig     <= w_sig;
      r_cnt     <= w_cnt;
      r_done    <= w_done;
      r_pass    <= w_pass;
      r_fail    <= w_fail;
      r_aborted <= w_aborted;
    end
  end
  assign bus.signature   = r_sig;
  assign bus.cycle_count = r_cnt;
  assign bus.done        = r_done;
  assign bus.pass        = r_pass;
  assign bus.fail        = r_fail;
  assign bus.aborted     = r_aborted;
endmodule

// File: tb/tb_bist_signature_analyzer.sv
// tb_bist_signature_analyzer: directed vector table plus reset and saturation sequences
module tb_bist_signature_analyzer;
  typedef struct packed {
    logic       run;
    logic       en;
    logic [3:0] d;
    logic [3:0] sig;
    logic [3:0] cnt;
    logic       done;
    logic       pass;
    logic       fail;
    logic       ab;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  bist_signature_analyzer_if #(.WIDTH(4), .CNT_W(4)) bus();
  bist_signature_analyzer #(
    .WIDTH(4), .POLY(4'h3), .SEED(4'h0), .GOLDEN(4'h8), .CNT_W(4), .EXP_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  task automatic add(input logic run, en, input logic [3:0] d, sig, cnt, input logic done, pass, fail, ab);
    tbl.push_back({run, en, d, sig, cnt, done, pass, fail, ab});
  endtask
  task automatic step(input logic run, en, input logic [3:0] d);
    bus.running  = run;
    bus.bist_end = en;
    bus.data_in  = d;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input logic [3:0] es, ec, input logic ed, ep, ef, ea);
    n_vec++;
    if ({bus.signature, bus.cycle_count, bus.done, bus.pass, bus.fail, bus.aborted} !== {es, ec, ed, ep, ef, ea}) begin
      n_err++;
      $display("FAIL %s: got sig=%h cnt=%0d done=%b pass=%b fail=%b ab=%b, want sig=%h cnt=%0d done=%b pass=%b fail=%b ab=%b",
               nm, bus.signature, bus.cycle_count, bus.done, bus.pass, bus.fail, bus.aborted, es, ec, ed, ep, ef, ea);
    end
  endtask
  task automatic apply(input int lo, hi);
    for (int i = lo; i <= hi; i++) begin
      step(tbl[i].run, tbl[i].en, tbl[i].d);
      check($sformatf("vec%0d", i), tbl[i].sig, tbl[i].cnt, tbl[i].done, tbl[i].pass, tbl[i].fail, tbl[i].ab);
    end
  endtask
  initial begin
    // case 1: 1,0,0,0 with bist_end on last word -> 8, pass; bist_end ignored in RESULT
    add(1, 0, 4'h1, 4'h1, 4'd1, 0, 0, 0, 0);
    add(1, 0, 4'h0, 4'h2, 4'd2, 0, 0, 0, 0);
    add(1, 0, 4'h0, 4'h4, 4'd3, 0, 0, 0, 0);
    add(1, 1, 4'h0, 4'h8, 4'd4, 0, 0, 0, 0);
    add(0, 0, 4'h0, 4'h8, 4'd4, 1, 1, 0, 0);
    add(0, 1, 4'h5, 4'h8, 4'd4, 1, 1, 0, 0);
    // case 2: 1,0,0,1 restarted from RESULT -> 9, fail
    add(1, 0, 4'h1, 4'h1, 4'd1, 0, 0, 0, 0);
    add(1, 0, 4'h0, 4'h2, 4'd2, 0, 0, 0, 0);
    add(1, 0, 4'h0, 4'h4, 4'd3, 0, 0, 0, 0);
    add(1, 1, 4'h1, 4'h9, 4'd4, 0, 0, 0, 0);
    add(0, 0, 4'h0, 4'h9, 4'd4, 1, 0, 1, 0);
    // case 3: five words, feedback on the fifth -> 3, count mismatch
    add(1, 0, 4'h1, 4'h1, 4'd1, 0, 0, 0, 0);
    add(1, 0, 4'h0, 4'h2, 4'd2, 0, 0, 0, 0);
    add(1, 0, 4'h0, 4'h4, 4'd3, 0, 0, 0, 0);
    add(1, 0, 4'h0, 4'h8, 4'd4, 0, 0, 0, 0);
    add(1, 1, 4'h0, 4'h3, 4'd5, 0, 0, 0, 0);
    add(0, 0, 4'h0, 4'h3, 4'd5, 1, 0, 1, 0);
    // bist_end one cycle after the last word: no step on that cycle
    add(1, 0, 4'h1, 4'h1, 4'd1, 0, 0, 0, 0);
    add(1, 0, 4'h0, 4'h2, 4'd2, 0, 0, 0, 0);
    add(1, 0, 4'h0, 4'h4, 4'd3, 0, 0, 0, 0);
    add(1, 0, 4'h0, 4'h8, 4'd4, 0, 0, 0, 0);
    add(0, 1, 4'h7, 4'h8, 4'd4, 0, 0, 0, 0);
    add(0, 0, 4'h0, 4'h8, 4'd4, 1, 1, 0, 0);
    // case 4: abort after two words, then IDLE holds and ignores bist_end
    add(1, 0, 4'h1, 4'h1, 4'd1, 0, 0, 0, 0);
    add(1, 0, 4'h0, 4'h2, 4'd2, 0, 0, 0, 0);
    add(0, 0, 4'h0, 4'h0, 4'd0, 0, 0, 0, 1);
    add(0, 0, 4'h0, 4'h0, 4'd0, 0, 0, 0, 0);
    add(0, 1, 4'h3, 4'h0, 4'd0, 0, 0, 0, 0);
    reset = 1'b1;
    step(0, 0, 4'h0);
    step(0, 0, 4'h0);
    check("reset", 4'h0, 4'd0, 0, 0, 0, 0);
    reset = 1'b0;
    apply(0, tbl.size() - 1);
    // case 5: reset mid-COMPACT with inputs that would otherwise abort
    step(1, 0, 4'h1);
    step(1, 0, 4'h0);
    check("pre_rst", 4'h2, 4'd2, 0, 0, 0, 0);
    reset = 1'b1;
    step(0, 0, 4'h0);
    check("rst_mid", 4'h0, 4'd0, 0, 0, 0, 0);
    reset = 1'b0;
    step(0, 0, 4'h0);
    check("rst_idle", 4'h0, 4'd0, 0, 0, 0, 0);
    apply(0, 4);
    // case 6: restart from RESULT, then 20 zero words saturate the count
    step(1, 0, 4'h1);
    check("restart", 4'h1, 4'd1, 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step(1, 0, 4'h0);
      if (k == 14) check("cnt15", 4'h9, 4'd15, 0, 0, 0, 0);
    end
    check("sat", 4'h6, 4'd15, 0, 0, 0, 0);
    step(0, 1, 4'h0);
    check("sat_cmp", 4'h6, 4'd15, 0, 0, 0, 0);
    step(0, 0, 4'h0);
    check("sat_res", 4'h6, 4'd15, 1, 0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
